// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - decode/execute stage bus: valid/ready handshake plus ID/EX payload
interface id_ex_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int SHAMT_W = 5,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 8
) ();
  logic               valid;
  logic               ready;
  logic [CTRL_W-1:0]  ctrl;
  logic [DATA_W-1:0]  rd1;
  logic [DATA_W-1:0]  rd2;
  logic [DATA_W-1:0]  immed;
  logic [FUNCT_W-1:0] funct;
  logic [SHAMT_W-1:0] shamt;
  logic [REG_W-1:0]   rt;
  logic [REG_W-1:0]   rd;

  modport master (
    output valid, ctrl, rd1, rd2, immed, funct, shamt, rt, rd,
    input  ready
  );

  modport slave (
    input  valid, ctrl, rd1, rd2, immed, funct, shamt, rt, rd,
    output ready
  );
endinterface

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX stage register with skid buffer, flush and saturating stall/bubble counters
module id_ex_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int SHAMT_W = 5,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_ex_pipe_if.slave      in_if,
  id_ex_pipe_if.master     out_if,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [DATA_W-1:0]  immed;
    logic [FUNCT_W-1:0] funct;
    logic [SHAMT_W-1:0] shamt;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
  } payload_t;

  // State bits are {main_valid, skid_valid}; ORPHAN cannot be reached but recovers by promoting the skid.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    ORPHAN = 2'b01,
    ONE    = 2'b10,
    FULL   = 2'b11
  } state_e;

  state_e     state_q;
  payload_t   main_q, main_d;
  payload_t   skid_q, skid_d;
  payload_t   in_payload;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic main_valid;
  logic skid_valid;
  logic in_ready;
  logic accept;
  logic drain;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign in_ready   = ~skid_valid;
  assign accept     = in_if.valid & in_ready;
  assign drain      = main_valid & out_if.ready;

  assign in_payload = '{
    ctrl:  in_if.ctrl,
    rd1:   in_if.rd1,
    rd2:   in_if.rd2,
    immed: in_if.immed,
    funct: in_if.funct,
    shamt: in_if.shamt,
    rt:    in_if.rt,
    rd:    in_if.rd
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_q <= ONE;
        ONE: begin
          if (accept && !drain)      state_q <= FULL;
          else if (!accept && drain) state_q <= EMPTY;
        end
        FULL:    if (drain) state_q <= ONE;
        ORPHAN:  state_q <= ONE;
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Payload slots load only when written; a flushed handshake leaves them untouched.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush) begin
      case (state_q)
        EMPTY: if (accept) main_d = in_payload;
        ONE: begin
          if (accept && drain) main_d = in_payload;
          else if (accept)     skid_d = in_payload;
        end
        FULL:    if (drain) main_d = skid_q;
        ORPHAN:  main_d = skid_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid && !out_if.ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!main_valid && out_if.ready && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  assign in_if.ready  = in_ready;
  assign out_if.valid = main_valid;
  assign out_if.ctrl  = main_valid ? main_q.ctrl : '0;
  assign out_if.rd1   = main_q.rd1;
  assign out_if.rd2   = main_q.rd2;
  assign out_if.immed = main_q.immed;
  assign out_if.funct = main_q.funct;
  assign out_if.shamt = main_q.shamt;
  assign out_if.rt    = main_q.rt;
  assign out_if.rd    = main_q.rd;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed self-checking bench for id_ex_pipe
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt, bubble_cnt;
  logic [1:0]  stall_cnt2, bubble_cnt2;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  id_ex_pipe_if in_if ();
  id_ex_pipe_if out_if ();
  id_ex_pipe_if in_if2 ();
  id_ex_pipe_if out_if2 ();

  id_ex_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_if      (in_if),
    .out_if     (out_if),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  id_ex_pipe #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_if      (in_if2),
    .out_if     (out_if2),
    .stall_cnt  (stall_cnt2),
    .bubble_cnt (bubble_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] tag);
    in_if.valid = v;
    in_if.ctrl  = tag;
    in_if.rd1   = {24'h0, tag};
    in_if.rd2   = ~{24'h0, tag};
    in_if.immed = {tag, tag, tag, tag};
    in_if.funct = tag[5:0];
    in_if.shamt = tag[4:0];
    in_if.rt    = tag[4:0];
    in_if.rd    = ~tag[4:0];
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h expected 0", out_if.valid); end
    n_checks++;
    if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h expected 1", in_if.ready); end
    n_checks++;
    if (out_if.ctrl !== 8'h00 || out_if.rd1 !== 32'h0 || out_if.immed !== 32'h0) begin
      n_fail++; $display("FAIL reset_payload: got ctrl=%0h rd1=%0h immed=%0h expected 0", out_if.ctrl, out_if.rd1, out_if.immed);
    end
    n_checks++;
    if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: got stall=%0d bubble=%0d expected 0/0", stall_cnt, bubble_cnt);
    end
  endtask

  task automatic test_streaming();
    drive(1'b1, 8'd1);
    out_if.ready = 1'b0;
    tick();
    n_checks++;
    if (out_if.valid !== 1'b1 || out_if.rd1 !== 32'd1) begin
      n_fail++; $display("FAIL stream_first: got valid=%0h rd1=%0h expected 1/1", out_if.valid, out_if.rd1);
    end
    out_if.ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      drive(1'b1, 8'(i));
      tick();
      n_checks++;
      if (out_if.valid !== 1'b1 || out_if.rd1 !== 32'(i) || in_if.ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d: got valid=%0h rd1=%0h in_ready=%0h expected 1/%0h/1", i, out_if.valid, out_if.rd1, in_if.ready, i);
      end
    end
    drive(1'b0, 8'd0);
    tick();
    out_if.ready = 1'b0;
    n_checks++;
    if (out_if.valid !== 1'b0 || bubble_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stream_end: got valid=%0h bubble=%0d stall=%0d expected 0/0/0", out_if.valid, bubble_cnt, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_if.ready = 1'b0;
    drive(1'b1, 8'h11);
    tick();
    drive(1'b1, 8'h22);
    tick();
    n_checks++;
    if (out_if.rd1 !== 32'h11 || out_if.ctrl !== 8'h11 || in_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got rd1=%0h ctrl=%0h in_ready=%0h expected 11/11/0", out_if.rd1, out_if.ctrl, in_if.ready);
    end
    drive(1'b1, 8'h33);
    tick();
    n_checks++;
    if (out_if.rd1 !== 32'h11 || in_if.ready !== 1'b0 || stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL bp_hold: got rd1=%0h in_ready=%0h stall=%0d expected 11/0/2", out_if.rd1, in_if.ready, stall_cnt);
    end
    out_if.ready = 1'b1;
    tick();
    n_checks++;
    if (out_if.rd1 !== 32'h22 || out_if.rd2 !== 32'hFFFF_FFDD || out_if.rd !== 5'h1D || in_if.ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_out_b: got rd1=%0h rd2=%0h rd=%0h in_ready=%0h expected 22/ffffffdd/1d/1", out_if.rd1, out_if.rd2, out_if.rd, in_if.ready);
    end
    tick();
    n_checks++;
    if (out_if.rd1 !== 32'h33 || out_if.immed !== 32'h3333_3333 || out_if.funct !== 6'h33) begin
      n_fail++; $display("FAIL bp_out_c: got rd1=%0h immed=%0h funct=%0h expected 33/33333333/33", out_if.rd1, out_if.immed, out_if.funct);
    end
    drive(1'b0, 8'h00);
    tick();
    out_if.ready = 1'b0;
    n_checks++;
    if (out_if.valid !== 1'b0 || out_if.ctrl !== 8'h00 || stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL bp_drained: got valid=%0h ctrl=%0h stall=%0d expected 0/0/2", out_if.valid, out_if.ctrl, stall_cnt);
    end
  endtask

  task automatic test_flush();
    out_if.ready = 1'b0;
    drive(1'b1, 8'h44);
    tick();
    drive(1'b1, 8'h55);
    tick();
    drive(1'b1, 8'h66);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00);
    n_checks++;
    if (out_if.valid !== 1'b0 || out_if.ctrl !== 8'h00 || in_if.ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_empty: got valid=%0h ctrl=%0h in_ready=%0h expected 0/0/1", out_if.valid, out_if.ctrl, in_if.ready);
    end
    n_checks++;
    if (stall_cnt !== 16'd4) begin
      n_fail++; $display("FAIL flush_stall_cnt: got %0d expected 4", stall_cnt);
    end
    tick();
    tick();
    n_checks++;
    if (out_if.valid !== 1'b0 || out_if.ctrl !== 8'h00) begin
      n_fail++; $display("FAIL flush_no_ghost: got valid=%0h ctrl=%0h expected 0/0", out_if.valid, out_if.ctrl);
    end
  endtask

  task automatic test_bubbles();
    drive(1'b0, 8'h00);
    out_if.ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (bubble_cnt !== 16'(i) || out_if.ctrl !== 8'h00) begin
        n_fail++; $display("FAIL bubble_%0d: got bubble=%0d ctrl=%0h expected %0d/0", i, bubble_cnt, out_if.ctrl, i);
      end
    end
    out_if.ready = 1'b0;
  endtask

  task automatic test_saturation();
    in_if2.valid = 1'b1;
    in_if2.ctrl  = 8'hA5;
    in_if2.rd1   = 32'h5;
    in_if2.rd2   = 32'h0;
    in_if2.immed = 32'h0;
    in_if2.funct = 6'h0;
    in_if2.shamt = 5'h0;
    in_if2.rt    = 5'h0;
    in_if2.rd    = 5'h0;
    out_if2.ready = 1'b0;
    tick();
    in_if2.valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if (stall_cnt2 !== 2'((i > 3) ? 3 : i) || out_if2.valid !== 1'b1) begin
        n_fail++; $display("FAIL sat_%0d: got stall=%0d valid=%0h expected %0d/1", i, stall_cnt2, out_if2.valid, (i > 3) ? 3 : i);
      end
    end
    n_checks++;
    if (bubble_cnt2 !== 2'd0) begin
      n_fail++; $display("FAIL sat_bubble: got %0d expected 0", bubble_cnt2);
    end
  endtask

  task automatic test_reset_midstream();
    out_if.ready = 1'b0;
    drive(1'b1, 8'h77);
    tick();
    drive(1'b1, 8'h88);
    tick();
    drive(1'b0, 8'h00);
    n_checks++;
    if (in_if.ready !== 1'b0 || stall_cnt !== 16'd5) begin
      n_fail++; $display("FAIL rst_pre_full: got in_ready=%0h stall=%0d expected 0/5", in_if.ready, stall_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1 || out_if.ctrl !== 8'h00 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_async: got valid=%0h in_ready=%0h ctrl=%0h stall=%0d expected 0/1/0/0", out_if.valid, in_if.ready, out_if.ctrl, stall_cnt);
    end
    n_checks++;
    if (out_if.rd1 !== 32'h0 || bubble_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin
      n_fail++; $display("FAIL rst_async_clear: got rd1=%0h bubble=%0d stall2=%0d expected 0/0/0", out_if.rd1, bubble_cnt, stall_cnt2);
    end
  endtask

  initial begin
    drive(1'b0, 8'h00);
    out_if.ready  = 1'b0;
    in_if2.valid  = 1'b0;
    in_if2.ctrl   = '0;
    in_if2.rd1    = '0;
    in_if2.rd2    = '0;
    in_if2.immed  = '0;
    in_if2.funct  = '0;
    in_if2.shamt  = '0;
    in_if2.rt     = '0;
    in_if2.rd     = '0;
    out_if2.ready = 1'b0;
    #12;
    test_reset();
    rst = 1'b1;
    tick();
    tick();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubbles();
    test_saturation();
    test_reset_midstream();
    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and saturating stall/bubble counters. It sits between decode and execute and replaces the fixed-width, always-advancing stage register. Upstream back-pressure is driven only from a register, so no combinational ready path spans the stage. Invalid slots present all-zero control, so execute sees a NOP bubble.

## Interface
- DATA_W, 32, width of rd1/rd2/immed
- REG_W, 5, register-index width (rt, rd)
- SHAMT_W, 5, shift-amount width
- FUNCT_W, 6, funct width
- CTRL_W, 8, packed control width, {W[1:0], M[1:0], E[3:0]} at default
- CNT_W, 16, width of each performance counter

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of every held entry
- in_valid  in  1  decode presents a valid entry
- in_ready  out  1  stage can accept; equals NOT skid_valid
- in_ctrl  in  CTRL_W  packed W/M/E control
- in_rd1, in_rd2, in_immed  in  DATA_W each  operands, sign-extended immediate
- in_funct  in  FUNCT_W
- in_shamt  in  SHAMT_W
- in_rt, in_rd  in  REG_W each
- out_valid  out  1  main slot holds a valid entry
- out_ready  in  1  execute consumes this cycle
- out_ctrl  out  CTRL_W  main-slot control when out_valid, else 0
- out_rd1, out_rd2, out_immed, out_funct, out_shamt, out_rt, out_rd  out  as inputs  main-slot payload
- stall_cnt  out  CNT_W  cycles with out_valid=1, out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0, out_ready=1

## Operation
- Storage: main slot (drives outputs) and skid slot, each a valid bit plus full payload (ctrl, rd1, rd2, immed, funct, shamt, rt, rd).
- accept = in_valid AND in_ready; drain = out_valid AND out_ready.
- States, encoded by (main_valid, skid_valid):
  - EMPTY (0,0): accept -> main loaded, go to ONE.
  - ONE (1,0): accept AND drain -> main reloaded from input, stay ONE; accept only -> input into skid, go to FULL; drain only -> go to EMPTY; neither -> hold.
  - FULL (1,1): in_ready=0; drain -> skid moves to main, skid cleared, go to ONE; else hold.
  - (0,1) is unreachable; if it occurs, the skid entry moves to main on the next edge.
- Order is strictly preserved: the skid entry always leaves before any newer input.
- flush=1: both valid bits cleared at the edge, go to EMPTY; an accept in the same cycle completes the handshake but its payload is discarded. Flush overrides accept and drain.
- Payload registers load only when their slot is written. Flush and reset clear valid bits, not payload (except at reset, see Timing).
- out_ctrl is combinationally gated to 0 when out_valid=0. Other payload outputs are not gated.
- Counters: saturate at 2^CNT_W-1, with no wrap. Only rst clears them; flush does not. Both counters evaluate every cycle, including flush cycles.

## Timing
- Reset (rst=0, asynchronous): both valid bits 0, all payload registers 0, both counters 0. Hence out_valid=0, in_ready=1, every out_* = 0. Release is synchronous to the next clk edge.
- Latency: an entry accepted at edge N appears on out_* after edge N (1 cycle) when main is free or draining. If the entry goes to the skid, it appears one cycle after the next drain.
- in_ready depends only on the skid valid flop. There is no combinational path from out_ready or in_valid to in_ready.
- Throughput: 1 entry/cycle while out_ready=1. Under back-pressure the stage holds 2 entries. After out_ready rises, in_ready rises 1 cycle later.
- A counter increment in cycle N is visible after edge N.

## Test plan
- Reset: assert rst=0 mid-stream while in FULL -> out_valid=0, in_ready=1, out_ctrl=0, stall_cnt=0 immediately, without waiting for clk.
- Streaming: out_ready=1, 8 back-to-back entries with in_rd1=1..8 -> out_rd1 shows 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1, bubble_cnt unchanged.
- Back-pressure: send A=0x11, B=0x22, C=0x33 with out_ready=0 -> A in main, B in skid, in_ready=0, C held. Then set out_ready=1 -> outputs A, B, C in order; stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush: in FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1, and the flushed-cycle input never appears.
- Bubbles: out_ready=1, in_valid=0 for 5 cycles -> bubble_cnt=5 and out_ctrl=0.
- Saturation: CNT_W=2, hold out_valid=1 with out_ready=0 for 6 cycles -> stall_cnt sticks at 3.
